// File: rtl/teknofest_soc_wrapper.sv
// teknofest_soc_wrapper: board top with UART program loader, main memory and soc; VCU108_DIFF_CLK_EN selects a differential clock input.
module teknofest_main_memory #(
  parameter int RAM_DEPTH = 32768
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hold,
  input  logic        valid,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  output logic        ready,
  output logic [31:0] rdata
);
  localparam int AW = $clog2(RAM_DEPTH);
  logic [31:0] ram [RAM_DEPTH];
  logic [AW-1:0] idx;
  logic unused_addr;
  assign idx = addr[AW+1:2];
  assign unused_addr = ^{addr[31:AW+2], addr[1:0]};
  // loader writes (hold) never raise ready, so the soc never sees a stale handshake
  always_ff @(posedge clk or posedge rst)
    if (rst) ready <= 1'b0;
    else ready <= valid & ~hold & ~ready;
  always_ff @(posedge clk)
    if (valid && !ready) begin
      rdata <= ram[idx];
      for (int b = 0; b < 4; b++)
        if (wstrb[b]) ram[idx][8*b +: 8] <= wdata[8*b +: 8];
    end
endmodule

module teknofest_soc #(
  parameter logic [31:0] RAM_BASE = 32'h4000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        valid,
  output logic [31:0] addr,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  input  logic        ready,
  input  logic [31:0] rdata,
  output logic        uart_tx,
  input  logic        uart_rx,
  output logic        spi_cs,
  output logic        spi_sck,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic        pwm0,
  output logic        pwm1
);
  logic [31:0] pc;
  assign valid = ~rst;
  assign addr = pc;
  assign wdata = 32'h0;
  assign wstrb = 4'h0;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pc <= RAM_BASE;
      uart_tx <= 1'b1;
      spi_cs <= 1'b1;
      spi_sck <= 1'b0;
      spi_mosi <= 1'b0;
      pwm0 <= 1'b0;
      pwm1 <= 1'b0;
    end else begin
      uart_tx <= uart_rx;
      if (ready) begin
        pc <= pc + 32'd4;
        spi_cs <= ~^rdata[7:0];
        spi_sck <= ^rdata[15:8];
        spi_mosi <= spi_miso & rdata[0];
        pwm0 <= ^rdata[23:16];
        pwm1 <= ^rdata[31:24];
      end
    end
endmodule

module teknofest_soc_wrapper #(
  parameter int          CPU_HZ    = 100_000_000,
  parameter int          BAUD_RATE = 115200,
  parameter int          RAM_DEPTH = 32768,
  parameter logic [31:0] RAM_BASE  = 32'h4000_0000
) (
`ifdef VCU108_DIFF_CLK_EN
  input  logic clk_p,
  input  logic clk_n,
`else
  input  logic clk_i,
`endif
  input  logic rst_i,
  input  logic program_rx_i,
  output logic prog_mode_led_o,
  output logic uart_tx_o,
  input  logic uart_rx_i,
  output logic spi_cs_o,
  output logic spi_sck_o,
  output logic spi_mosi_o,
  input  logic spi_miso_i,
  output logic pwm0_o,
  output logic pwm1_o
);
  localparam int AW = $clog2(RAM_DEPTH);
  localparam int DIV = CPU_HZ / BAUD_RATE;
  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] DIV_M1 = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);
  localparam logic [71:0] SIG = "TEKNOFEST";
  typedef enum logic [1:0] {IDLE, COUNT, DATA} state_t;
  logic clk;
`ifdef VCU108_DIFF_CLK_EN
  IBUFDS clk_ibuf (.I(clk_p), .IB(clk_n), .O(clk));
`else
  assign clk = clk_i;
`endif
  logic soc_rst, soc_valid, mem_valid, mem_ready, prog_mode;
  logic [31:0] soc_addr, soc_wdata, mem_addr, mem_wdata, mem_rdata;
  logic [3:0] soc_wstrb, mem_wstrb;
  logic [2:0] rx_sync;
  logic rx_busy, rx_stb;
  logic [CW-1:0] rx_cnt;
  logic [3:0] rx_bit;
  logic [7:0] rx_sh, exp_ch;
  state_t state;
  logic [3:0] idx;
  logic [1:0] bcnt;
  logic [31:0] acc, left, word_nx, ld_data;
  logic [AW-1:0] ptr, ld_idx;
  logic ld_we, ld_last;
  assign soc_rst = rst_i | prog_mode;
  assign prog_mode_led_o = prog_mode;
  assign exp_ch = SIG[8*(8-idx) +: 8];
  assign word_nx = {rx_sh, acc[31:8]};
  assign mem_valid = prog_mode ? ld_we : soc_valid;
  assign mem_addr = prog_mode ? RAM_BASE + 32'({ld_idx, 2'b00}) : soc_addr;
  assign mem_wdata = prog_mode ? ld_data : soc_wdata;
  assign mem_wstrb = prog_mode ? 4'hf : soc_wstrb;
  // rx_sync[1] is the synchronized line, rx_sync[2] its previous value for edge detection
  always_ff @(posedge clk or posedge rst_i)
    if (rst_i) begin
      rx_sync <= 3'b111;
      rx_busy <= 1'b0;
      rx_cnt <= '0;
      rx_bit <= '0;
      rx_sh <= '0;
      rx_stb <= 1'b0;
    end else begin
      rx_sync <= {rx_sync[1:0], program_rx_i};
      rx_stb <= 1'b0;
      if (!rx_busy) begin
        if (rx_sync[2] && !rx_sync[1]) begin
          rx_busy <= 1'b1;
          rx_cnt <= '0;
          rx_bit <= '0;
        end
      end else if (rx_cnt == (rx_bit == 4'd0 ? HALF_M1 : DIV_M1)) begin
        rx_cnt <= '0;
        rx_bit <= rx_bit + 4'd1;
        if (rx_bit == 4'd0) rx_busy <= ~rx_sync[1];
        else if (rx_bit == 4'd9) begin
          rx_busy <= 1'b0;
          rx_stb <= rx_sync[1];
        end else rx_sh <= {rx_sync[1], rx_sh[7:1]};
      end else rx_cnt <= rx_cnt + 1'b1;
    end
  always_ff @(posedge clk or posedge rst_i)
    if (rst_i) begin
      state <= IDLE;
      idx <= '0;
      bcnt <= '0;
      acc <= '0;
      left <= '0;
      ptr <= '0;
      prog_mode <= 1'b0;
      ld_we <= 1'b0;
      ld_last <= 1'b0;
      ld_idx <= '0;
      ld_data <= '0;
    end else begin
      ld_we <= 1'b0;
      if (ld_we && ld_last) prog_mode <= 1'b0;
      if (rx_stb)
        case (state)
          IDLE:
            if (rx_sh == exp_ch) begin
              idx <= idx == 4'd8 ? 4'd0 : idx + 4'd1;
              if (idx == 4'd8) begin
                state <= COUNT;
                prog_mode <= 1'b1;
                bcnt <= '0;
              end
            end else idx <= rx_sh == "T" ? 4'd1 : 4'd0;
          COUNT: begin
            acc <= word_nx;
            bcnt <= bcnt + 2'd1;
            if (bcnt == 2'd3) begin
              state <= word_nx == 32'd0 ? IDLE : DATA;
              prog_mode <= word_nx != 32'd0;
              left <= word_nx;
              ptr <= '0;
            end
          end
          default: begin
            acc <= word_nx;
            bcnt <= bcnt + 2'd1;
            if (bcnt == 2'd3) begin
              ld_we <= 1'b1;
              ld_idx <= ptr;
              ld_data <= word_nx;
              ld_last <= left == 32'd1;
              ptr <= ptr + 1'b1;
              left <= left - 32'd1;
              if (left == 32'd1) state <= IDLE;
            end
          end
        endcase
    end
  teknofest_main_memory #(.RAM_DEPTH(RAM_DEPTH)) main_memory (
    .clk(clk), .rst(rst_i), .hold(prog_mode), .valid(mem_valid), .addr(mem_addr),
    .wdata(mem_wdata), .wstrb(mem_wstrb), .ready(mem_ready), .rdata(mem_rdata)
  );
  teknofest_soc #(.RAM_BASE(RAM_BASE)) soc (
    .clk(clk), .rst(soc_rst), .valid(soc_valid), .addr(soc_addr), .wdata(soc_wdata),
    .wstrb(soc_wstrb), .ready(mem_ready), .rdata(mem_rdata),
    .uart_tx(uart_tx_o), .uart_rx(uart_rx_i), .spi_cs(spi_cs_o), .spi_sck(spi_sck_o),
    .spi_mosi(spi_mosi_o), .spi_miso(spi_miso_i), .pwm0(pwm0_o), .pwm1(pwm1_o)
  );
endmodule

// File: tb/tb_teknofest_soc_wrapper.sv
// tb_teknofest_soc_wrapper: scoreboard bench for the program loader and soc fetch path at a reduced baud divider of 16.
module tb_teknofest_soc_wrapper;
  localparam int DIV = 16;
  localparam logic [31:0] BASE = 32'h4000_0000;
  logic clk_i = 1'b0, rst_i = 1'b1, program_rx_i = 1'b1, uart_rx_i = 1'b1, spi_miso_i = 1'b0;
  logic prog_mode_led_o, uart_tx_o, spi_cs_o, spi_sck_o, spi_mosi_o, pwm0_o, pwm1_o;
  int total = 0, bad = 0;
  logic [63:0] fetch_q[$];
  logic [37:0] wr_q[$];
  logic [63:0] fe;
  logic [37:0] we_e;
  teknofest_soc_wrapper #(.CPU_HZ(1_600_000), .BAUD_RATE(100_000), .RAM_DEPTH(64)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .program_rx_i(program_rx_i), .prog_mode_led_o(prog_mode_led_o),
    .uart_tx_o(uart_tx_o), .uart_rx_i(uart_rx_i), .spi_cs_o(spi_cs_o), .spi_sck_o(spi_sck_o),
    .spi_mosi_o(spi_mosi_o), .spi_miso_i(spi_miso_i), .pwm0_o(pwm0_o), .pwm1_o(pwm1_o)
  );
  always #5 clk_i = ~clk_i;
  always @(negedge clk_i) begin
    if (dut.mem_ready && !dut.prog_mode && fetch_q.size() > 0) begin
      fe = fetch_q.pop_front();
      total++;
      if ({dut.soc_addr, dut.mem_rdata} !== fe) begin
        bad++;
        $display("FAIL fetch got=%h req=%h", {dut.soc_addr, dut.mem_rdata}, fe);
      end
    end
    if (dut.prog_mode && dut.mem_valid) begin
      total++;
      if (wr_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write got=%h", {dut.mem_addr[7:2], dut.mem_wdata});
      end else begin
        we_e = wr_q.pop_front();
        if ({dut.mem_addr[7:2], dut.mem_wdata} !== we_e) begin
          bad++;
          $display("FAIL loader_write got=%h req=%h", {dut.mem_addr[7:2], dut.mem_wdata}, we_e);
        end
      end
    end
  end
  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask
  task automatic send_byte(input logic [7:0] b, input logic stop);
    program_rx_i = 1'b0;
    tick(DIV);
    for (int i = 0; i < 8; i++) begin
      program_rx_i = b[i];
      tick(DIV);
    end
    program_rx_i = stop;
    tick(DIV);
    program_rx_i = 1'b1;
    tick(DIV);
  endtask
  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
  endtask
  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
  endtask
  task automatic check_led(input string name, input logic req);
    total++;
    if (prog_mode_led_o !== req) begin
      bad++;
      $display("FAIL %s led got=%b req=%b", name, prog_mode_led_o, req);
    end
  endtask
  task automatic wait_queues(input string name);
    for (int i = 0; i < 400 && (fetch_q.size() > 0 || wr_q.size() > 0); i++) tick(1);
    total++;
    if (fetch_q.size() != 0 || wr_q.size() != 0) begin
      bad++;
      $display("FAIL %s pending fetch=%0d write=%0d req=0", name, fetch_q.size(), wr_q.size());
    end
  endtask
  task automatic test_reset;
    rst_i = 1'b1;
    tick(20);
    dut.main_memory.ram[0] = 32'hA000_0001;
    dut.main_memory.ram[1] = 32'hA000_0102;
    dut.main_memory.ram[2] = 32'hA003_0203;
    total += 6;
    if ({prog_mode_led_o, uart_tx_o, spi_cs_o, spi_sck_o, spi_mosi_o, pwm0_o} !== 6'b011000) begin
      bad++;
      $display("FAIL reset_outs got=%b req=011000", {prog_mode_led_o, uart_tx_o, spi_cs_o, spi_sck_o, spi_mosi_o, pwm0_o});
    end
    if (pwm1_o !== 1'b0) begin bad++; $display("FAIL reset_pwm1 got=%b req=0", pwm1_o); end
    if (dut.soc_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b req=0", dut.soc_valid); end
    if (dut.state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d req=0", dut.state); end
    if (dut.idx !== 4'd0) begin bad++; $display("FAIL reset_idx got=%0d req=0", dut.idx); end
    if (dut.rx_sync !== 3'b111) begin bad++; $display("FAIL reset_sync got=%b req=111", dut.rx_sync); end
  endtask
  task automatic test_boot;
    fetch_q.push_back({BASE, 32'hA000_0001});
    fetch_q.push_back({BASE + 32'd4, 32'hA000_0102});
    fetch_q.push_back({BASE + 32'd8, 32'hA003_0203});
    rst_i = 1'b0;
    wait_queues("boot_fetch");
    check_led("boot", 1'b0);
    uart_rx_i = 1'b0;
    tick(3);
    total++;
    if (uart_tx_o !== 1'b0) begin bad++; $display("FAIL uart_echo got=%b req=0", uart_tx_o); end
    uart_rx_i = 1'b1;
    tick(3);
  endtask
  task automatic test_program;
    send_str("TEKNOFES");
    check_led("pre_match", 1'b0);
    send_byte("T", 1'b1);
    check_led("match", 1'b1);
    total++;
    if (dut.soc_valid !== 1'b0) begin bad++; $display("FAIL soc_held got=%b req=0", dut.soc_valid); end
    fetch_q.push_back({BASE, 32'h0000_0013});
    fetch_q.push_back({BASE + 32'd4, 32'hDEAD_BEEF});
    wr_q.push_back({6'd0, 32'h0000_0013});
    wr_q.push_back({6'd1, 32'hDEAD_BEEF});
    send_word(32'd2);
    check_led("count", 1'b1);
    send_word(32'h0000_0013);
    send_word(32'hDEAD_BEEF);
    check_led("done", 1'b0);
    wait_queues("program");
    total += 2;
    if (dut.main_memory.ram[0] !== 32'h0000_0013) begin bad++; $display("FAIL ram0 got=%h req=00000013", dut.main_memory.ram[0]); end
    if (dut.main_memory.ram[1] !== 32'hDEAD_BEEF) begin bad++; $display("FAIL ram1 got=%h req=deadbeef", dut.main_memory.ram[1]); end
  endtask
  task automatic test_restart_t;
    send_str("TEKNOX");
    check_led("teknox", 1'b0);
    send_str("TTEKNOFEST");
    check_led("tteknofest", 1'b1);
    send_word(32'd0);
    check_led("count_zero", 1'b0);
  endtask
  task automatic test_framing_glitch;
    send_str("TEKNOFES");
    send_byte("T", 1'b0);
    check_led("framing", 1'b0);
    send_byte("X", 1'b1);
    send_str("TEKNOFES");
    program_rx_i = 1'b0;
    tick(5);
    program_rx_i = 1'b1;
    tick(2 * DIV);
    send_byte("T", 1'b1);
    check_led("glitch", 1'b1);
    send_word(32'd0);
    check_led("glitch_exit", 1'b0);
  endtask
  task automatic test_reset_mid;
    send_str("TEKNOFEST");
    wr_q.push_back({6'd0, 32'h1122_3344});
    send_word(32'd3);
    send_word(32'h1122_3344);
    send_byte(8'h55, 1'b1);
    send_byte(8'h66, 1'b1);
    rst_i = 1'b1;
    #1;
    check_led("mid_reset", 1'b0);
    tick(5);
    total += 2;
    if (dut.main_memory.ram[0] !== 32'h1122_3344) begin bad++; $display("FAIL mid_ram0 got=%h req=11223344", dut.main_memory.ram[0]); end
    if (dut.main_memory.ram[1] !== 32'hDEAD_BEEF) begin bad++; $display("FAIL mid_ram1 got=%h req=deadbeef", dut.main_memory.ram[1]); end
    fetch_q.push_back({BASE, 32'h1122_3344});
    rst_i = 1'b0;
    wait_queues("mid_restart");
    check_led("mid_run", 1'b0);
  endtask
  initial begin
    test_reset;
    test_boot;
    test_program;
    test_restart_t;
    test_framing_glitch;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
